// File: rtl/p4_router_ingress_port_packer.sv
// Per-port width adapter: packs narrow AXI-Stream beats into wide ingress-bus words,
// drops zero-byte packets and truncates packets longer than MTU_BYTES.
module p4_router_ingress_port_packer #(
  parameter int IN_DATA_BYTES  = 8,
  parameter int OUT_DATA_BYTES = 32,
  parameter int MTU_BYTES      = 1500
) (
  input  logic                          clk,
  input  logic                          sresetn,
  input  logic                          phys_tvalid,
  output logic                          phys_tready,
  input  logic [IN_DATA_BYTES*8-1:0]    phys_tdata,
  input  logic [IN_DATA_BYTES-1:0]      phys_tkeep,
  input  logic                          phys_tlast,
  output logic                          adapted_tvalid,
  input  logic                          adapted_tready,
  output logic [OUT_DATA_BYTES*8-1:0]   adapted_tdata,
  output logic [OUT_DATA_BYTES-1:0]     adapted_tkeep,
  output logic [OUT_DATA_BYTES-1:0]     adapted_tstrb,
  output logic                          adapted_tlast,
  output logic [7:0]                    adapted_tid,
  output logic [7:0]                    adapted_tdest,
  output logic [0:0]                    adapted_tuser,
  output logic                          trunc_pulse,
  output logic                          empty_drop_pulse
);

  localparam int RATIO      = OUT_DATA_BYTES / IN_DATA_BYTES;
  localparam int LANE_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CNT_W      = $clog2(MTU_BYTES + 1);
  localparam int BEAT_CNT_W = $clog2(IN_DATA_BYTES + 1);
  localparam int OUT_W      = OUT_DATA_BYTES * 8;

  if ((OUT_DATA_BYTES % IN_DATA_BYTES) != 0 || OUT_DATA_BYTES < IN_DATA_BYTES) begin : g_bad_ratio
    $error("OUT_DATA_BYTES must be a positive integer multiple of IN_DATA_BYTES");
  end

  typedef enum logic [0:0] {S_ACCUM = 1'b0, S_DISCARD = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;
  logic [OUT_W-1:0]            stage_q, stage_d;
  logic                        out_valid_q, out_valid_d;
  logic [OUT_W-1:0]            out_data_q, out_data_d;
  logic [OUT_DATA_BYTES-1:0]   out_keep_q, out_keep_d;
  logic                        out_last_q, out_last_d;
  logic                        trunc_q, trunc_d;
  logic                        empty_q, empty_d;

  function automatic logic [BEAT_CNT_W-1:0] keep_count(input logic [IN_DATA_BYTES-1:0] k);
    logic [BEAT_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < IN_DATA_BYTES; i++) c = c + BEAT_CNT_W'(k[i]);
    return c;
  endfunction

  function automatic logic [OUT_DATA_BYTES-1:0] keep_mask(input int nbytes);
    logic [OUT_DATA_BYTES-1:0] m;
    for (int i = 0; i < OUT_DATA_BYTES; i++) m[i] = (i < nbytes);
    return m;
  endfunction

  // Discard mode swallows the tail of a truncated packet even while the output is full.
  assign phys_tready = (state_q == S_DISCARD) || !out_valid_q || adapted_tready;

  always_comb begin
    logic [BEAT_CNT_W-1:0] beat_bytes;
    logic [OUT_W-1:0]      staged;
    logic                  accept;
    logic                  over_mtu;
    logic                  complete;
    int                    sum_bytes;
    int                    take_bytes;
    int                    word_bytes;

    state_d     = state_q;
    lane_d      = lane_q;
    byte_cnt_d  = byte_cnt_q;
    stage_d     = stage_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    trunc_d     = 1'b0;
    empty_d     = 1'b0;

    accept     = phys_tvalid && phys_tready;
    beat_bytes = keep_count(phys_tkeep);
    sum_bytes  = int'(byte_cnt_q) + int'(beat_bytes);
    over_mtu   = (sum_bytes > MTU_BYTES);
    take_bytes = over_mtu ? (MTU_BYTES - int'(byte_cnt_q)) : int'(beat_bytes);
    word_bytes = int'(lane_q) * IN_DATA_BYTES + take_bytes;
    complete   = (int'(lane_q) == RATIO - 1) || phys_tlast || over_mtu;

    // Bytes past take_bytes stay zero so unused output lanes are clean.
    staged = stage_q;
    for (int l = 0; l < RATIO; l++) begin
      for (int b = 0; b < IN_DATA_BYTES; b++) begin
        if (l == int'(lane_q) && b < take_bytes)
          staged[(l*IN_DATA_BYTES+b)*8 +: 8] = phys_tdata[b*8 +: 8];
      end
    end

    if (out_valid_q && adapted_tready) out_valid_d = 1'b0;

    if (accept) begin
      if (state_q == S_DISCARD) begin
        if (phys_tlast) state_d = S_ACCUM;
      end else if (phys_tlast && beat_bytes == '0 && byte_cnt_q == '0) begin
        empty_d = 1'b1;
      end else if (phys_tlast || beat_bytes != '0) begin
        if (complete) begin
          out_valid_d = 1'b1;
          out_data_d  = staged;
          out_keep_d  = keep_mask(word_bytes);
          out_last_d  = phys_tlast || over_mtu;
          stage_d     = '0;
          lane_d      = '0;
        end else begin
          stage_d = staged;
          lane_d  = lane_q + LANE_W'(1);
        end
        byte_cnt_d = (phys_tlast || over_mtu) ? '0 : CNT_W'(int'(byte_cnt_q) + take_bytes);
        trunc_d    = over_mtu;
        if (over_mtu && !phys_tlast) state_d = S_DISCARD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q     <= S_ACCUM;
      lane_q      <= '0;
      byte_cnt_q  <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      trunc_q     <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      byte_cnt_q  <= byte_cnt_d;
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      trunc_q     <= trunc_d;
      empty_q     <= empty_d;
    end
  end

  assign adapted_tvalid   = out_valid_q;
  assign adapted_tdata    = out_data_q;
  assign adapted_tkeep    = out_keep_q;
  assign adapted_tlast    = out_last_q;
  assign adapted_tstrb    = '1;
  assign adapted_tid      = '0;
  assign adapted_tdest    = '0;
  assign adapted_tuser    = '0;
  assign trunc_pulse      = trunc_q;
  assign empty_drop_pulse = empty_q;

endmodule

// File: tb/tb_p4_router_ingress_port_packer.sv
// Scoreboard bench for the ingress port packer (8 -> 32 bytes, MTU 1500).
module tb_p4_router_ingress_port_packer;

  localparam int IN    = 8;
  localparam int OUT   = 32;
  localparam int MTU   = 1500;
  localparam int RATIO = OUT / IN;

  logic           clk = 1'b0;
  logic           sresetn;
  logic           phys_tvalid;
  logic           phys_tready;
  logic [IN*8-1:0] phys_tdata;
  logic [IN-1:0]  phys_tkeep;
  logic           phys_tlast;
  logic           adapted_tvalid;
  logic           adapted_tready;
  logic [OUT*8-1:0] adapted_tdata;
  logic [OUT-1:0] adapted_tkeep;
  logic [OUT-1:0] adapted_tstrb;
  logic           adapted_tlast;
  logic [7:0]     adapted_tid;
  logic [7:0]     adapted_tdest;
  logic [0:0]     adapted_tuser;
  logic           trunc_pulse;
  logic           empty_drop_pulse;

  always #5 clk = ~clk;

  p4_router_ingress_port_packer #(
    .IN_DATA_BYTES(IN), .OUT_DATA_BYTES(OUT), .MTU_BYTES(MTU)
  ) dut (
    .clk(clk), .sresetn(sresetn),
    .phys_tvalid(phys_tvalid), .phys_tready(phys_tready), .phys_tdata(phys_tdata),
    .phys_tkeep(phys_tkeep), .phys_tlast(phys_tlast),
    .adapted_tvalid(adapted_tvalid), .adapted_tready(adapted_tready),
    .adapted_tdata(adapted_tdata), .adapted_tkeep(adapted_tkeep), .adapted_tstrb(adapted_tstrb),
    .adapted_tlast(adapted_tlast), .adapted_tid(adapted_tid), .adapted_tdest(adapted_tdest),
    .adapted_tuser(adapted_tuser), .trunc_pulse(trunc_pulse), .empty_drop_pulse(empty_drop_pulse)
  );

  typedef struct packed {
    logic [OUT*8-1:0] data;
    logic [OUT-1:0]   keep;
    logic             last;
  } word_t;

  word_t      sb[$];
  logic [7:0] pkt[$];
  int errors = 0;
  int checks = 0;
  int trunc_cnt = 0;
  int empty_cnt = 0;
  int ptr_low_cnt = 0;
  bit rand_rdy = 1'b0;
  bit held = 1'b0;
  word_t prev;

  // Output monitor: scoreboard pop on every handshake, hold check while stalled.
  always @(negedge clk) begin
    word_t act;
    word_t exp;
    act = {adapted_tdata, adapted_tkeep, adapted_tlast};
    if (sresetn) begin
      if (held) begin
        checks++;
        if (!adapted_tvalid || act !== prev) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b keep=%h last=%0b, required valid=1 keep=%h last=%0b",
                   adapted_tvalid, act.keep, act.last, prev.keep, prev.last);
        end
      end
      if (adapted_tvalid && adapted_tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got keep=%h last=%0b, required no word", act.keep, act.last);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL word: got data=%h keep=%h last=%0b, required data=%h keep=%h last=%0b",
                     act.data, act.keep, act.last, exp.data, exp.keep, exp.last);
          end
        end
      end
      held = adapted_tvalid && !adapted_tready;
      prev = act;
      if (trunc_pulse) trunc_cnt++;
      if (empty_drop_pulse) empty_cnt++;
      if (!phys_tready) ptr_low_cnt++;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) adapted_tready = (($urandom % 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic build_expected(input int len);
    int eff;
    int nw;
    eff = (len > MTU) ? MTU : len;
    nw  = (eff + OUT - 1) / OUT;
    for (int w = 0; w < nw; w++) begin
      word_t e;
      e = '0;
      for (int b = 0; b < OUT; b++) begin
        if (w*OUT + b < eff) begin
          e.data[b*8 +: 8] = pkt[w*OUT + b];
          e.keep[b] = 1'b1;
        end
      end
      e.last = (w == nw - 1);
      sb.push_back(e);
    end
  endtask

  task automatic drive_beat(input logic [IN*8-1:0] d, input logic [IN-1:0] k, input logic l,
                            output int waited);
    phys_tdata  = d;
    phys_tkeep  = k;
    phys_tlast  = l;
    phys_tvalid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!phys_tready && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 500) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got tready=0 for %0d cycles, required acceptance", waited);
    end
    @(posedge clk);
    #1;
    phys_tvalid = 1'b0;
    phys_tlast  = 1'b0;
    phys_tkeep  = '0;
    phys_tdata  = '0;
  endtask

  // Garbage is placed in bytes beyond tkeep so the DUT has to zero them itself.
  task automatic send_packet(input int len, input int null_at, input int stall_from, input bit lat_chk);
    int nb;
    int w;
    logic [IN*8-1:0] d;
    logic [IN-1:0] k;
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    build_expected(len);
    if (len == 0) begin
      drive_beat({$urandom, $urandom}, '0, 1'b1, w);
      return;
    end
    nb = (len + IN - 1) / IN;
    for (int i = 0; i < nb; i++) begin
      if (i == null_at) drive_beat({$urandom, $urandom}, '0, 1'b0, w);
      if (i == stall_from) adapted_tready = 1'b0;
      d = {$urandom, $urandom};
      k = '0;
      for (int b = 0; b < IN; b++) begin
        if (i*IN + b < len) begin
          d[b*8 +: 8] = pkt[i*IN + b];
          k[b] = 1'b1;
        end
      end
      drive_beat(d, k, (i == nb - 1), w);
      if (stall_from >= 0 && i >= stall_from) begin
        checks++;
        if (w !== 0) begin
          errors++;
          $display("FAIL discard_ready: beat %0d waited %0d cycles, required 0", i, w);
        end
      end
      if (lat_chk) begin
        logic exp_v;
        exp_v = ((i % RATIO) == RATIO - 1) || (i == nb - 1);
        checks++;
        if (adapted_tvalid !== exp_v) begin
          errors++;
          $display("FAIL latency: after beat %0d got tvalid=%0b, required %0b", i, adapted_tvalid, exp_v);
        end
      end
    end
    if (stall_from >= 0) adapted_tready = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || adapted_tvalid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || adapted_tvalid) begin
      errors++;
      $display("FAIL drain: got %0d words outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    sresetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (adapted_tvalid !== 1'b0 || adapted_tlast !== 1'b0 || adapted_tkeep !== '0 || adapted_tdata !== '0) begin
      errors++;
      $display("FAIL reset_out: got valid=%0b last=%0b keep=%h, required all zero",
               adapted_tvalid, adapted_tlast, adapted_tkeep);
    end
    checks++;
    if (trunc_pulse !== 1'b0 || empty_drop_pulse !== 1'b0 || phys_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: got trunc=%0b empty=%0b tready=%0b, required 0 0 1",
               trunc_pulse, empty_drop_pulse, phys_tready);
    end
    checks++;
    if (adapted_tstrb !== '1 || adapted_tid !== '0 || adapted_tdest !== '0 || adapted_tuser !== '0) begin
      errors++;
      $display("FAIL sideband: got strb=%h id=%h dest=%h user=%h, required strb all ones rest zero",
               adapted_tstrb, adapted_tid, adapted_tdest, adapted_tuser);
    end
    sresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_packet();
    send_packet(64, -1, -1, 1'b1);
    wait_drain();
  endtask

  task automatic test_short_packet();
    send_packet(13, -1, -1, 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = ptr_low_cnt;
    fork
      send_packet(128, -1, -1, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1 adapted_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1 adapted_tready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (ptr_low_cnt == p0) begin
      errors++;
      $display("FAIL bp_tready: got phys tready never low, required low while output full");
    end
  endtask

  task automatic test_truncation();
    int t0;
    t0 = trunc_cnt;
    send_packet(1600, -1, 188, 1'b0);
    wait_drain();
    checks++;
    if (trunc_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL trunc_pulse: got %0d pulses, required 1", trunc_cnt - t0);
    end
    send_packet(64, -1, -1, 1'b0);
    wait_drain();
    checks++;
    if (trunc_cnt - t0 !== 1) begin
      errors++;
      $display("FAIL trunc_after: got %0d pulses, required 1", trunc_cnt - t0);
    end
  endtask

  task automatic test_null_beats();
    int e0;
    int t0;
    e0 = empty_cnt;
    t0 = trunc_cnt;
    send_packet(0, -1, -1, 1'b0);
    wait_drain();
    checks++;
    if (empty_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL empty_drop: got %0d pulse cycles, required 1", empty_cnt - e0);
    end
    send_packet(24, 1, -1, 1'b0);
    wait_drain();
    checks++;
    if (empty_cnt - e0 !== 1 || trunc_cnt != t0) begin
      errors++;
      $display("FAIL null_mid_pulses: got empty=%0d trunc=%0d, required 1 0", empty_cnt - e0, trunc_cnt - t0);
    end
  endtask

  task automatic test_reset_mid_packet();
    int w;
    for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, '1, 1'b0, w);
    sresetn = 1'b0;
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    checks++;
    if (adapted_tvalid !== 1'b0 || phys_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid=%0b tready=%0b, required 0 1", adapted_tvalid, phys_tready);
    end
    send_packet(32, -1, -1, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back_random();
    int len;
    rand_rdy = 1'b1;
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(1, 100);
      send_packet(len, ((p % 2) == 1 && len > 16) ? 1 : -1, -1, 1'b0);
    end
    wait_drain();
    rand_rdy = 1'b0;
    adapted_tready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    sresetn        = 1'b0;
    phys_tvalid    = 1'b0;
    phys_tdata     = '0;
    phys_tkeep     = '0;
    phys_tlast     = 1'b0;
    adapted_tready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_full_packet();
    test_short_packet();
    test_backpressure();
    test_truncation();
    test_null_beats();
    test_reset_mid_packet();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
